// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: opcodes, FSM states,
// flag bit positions and the opcode legality / flag-mask helpers.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_INC  = 4'h2,
    OP_DEC  = 4'h3,
    OP_PASS = 4'h4,
    OP_SHL  = 4'h5,
    OP_BADD = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_NOT  = 4'hA,
    OP_NEG  = 4'hB
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam int FLG_C = 3;
  localparam int FLG_O = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_S = 0;

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return op <= OP_NEG;
  endfunction

  // Which of {C,O,Z,S} are meaningful for a given opcode.
  function automatic logic [3:0] flag_mask(
    input logic [3:0] op
  );
    logic [3:0] m;
    m = '0;
    if (op_legal(op)) m[FLG_Z] = 1'b1;
    if (op == OP_ADD) m[FLG_C] = 1'b1;
    if (op == OP_ADD || op == OP_SUB) begin
      m[FLG_O] = 1'b1;
      m[FLG_S] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command / ALU / response bundle for the ALU operation sequencer.
// slave = sequencer side, master = command source, ALU and consumer.
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_chain;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_cf;
  logic        alu_of;
  logic        alu_zf;
  logic        alu_sf;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_out, alu_cf, alu_of, alu_zf, alu_sf,
    output rsp_valid, rsp_data, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_out, alu_cf, alu_of, alu_zf, alu_sf,
    input  rsp_valid, rsp_data, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one op at a time through an external combinational ALU.
// Define ALU_SEQ_CHAIN_EN to let cmd_chain feed the last result to A.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1
) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic [31:0] a_sel;
  logic [3:0]  raw_flags;

  assign raw_flags = {bus.alu_cf, bus.alu_of,
                      bus.alu_zf, bus.alu_sf};

`ifdef ALU_SEQ_CHAIN_EN
  logic [31:0] chain_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      chain_q <= bus.alu_out;
    end
  end

  assign a_sel = bus.cmd_chain ? chain_q : bus.cmd_a;
`else
  logic unused_chain;

  assign unused_chain = bus.cmd_chain;
  assign a_sel        = bus.cmd_a;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          if (op_legal(bus.cmd_op)) begin
            a_d     = a_sel;
            b_d     = bus.cmd_b;
            op_d    = bus.cmd_op;
            cnt_d   = SETTLE_LD;
            state_d = ST_DRIVE;
          end else begin
            // Illegal op bypasses the ALU; operands stay untouched.
            data_d  = '0;
            flags_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        data_d  = bus.alu_out;
        flags_d = flag_mask(op_q) & raw_flags;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU
// and reference model; a second instance covers SETTLE_CYC=4.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int S1 = 1;
  localparam int S4 = 4;
`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [31:0] junk = '0;
  always @(posedge clk) junk <= $urandom;

  alu_op_sequencer_if bus();
  alu_op_sequencer_if bus4();

  alu_op_sequencer #(.SETTLE_CYC(S1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  alu_op_sequencer #(.SETTLE_CYC(S4)) u_dut4 (
    .clk(clk), .rst(rst4), .bus(bus4)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        o;
  } alu_res_t;

  function automatic alu_res_t alu_f(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    alu_res_t x;
    logic [32:0] w;
    x = '0;
    w = '0;
    case (op)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b};
        x.r = w[31:0];
        x.c = w[32];
        x.o = (a[31] == b[31]) && (x.r[31] != a[31]);
      end
      4'h1: begin
        x.r = a - b;
        x.c = (a < b);
        x.o = (a[31] != b[31]) && (x.r[31] != a[31]);
      end
      4'h2: x.r = a + 32'd1;
      4'h3: x.r = a - 32'd1;
      4'h4: x.r = a;
      4'h5: x.r = a << b[4:0];
      4'h6: x.r = {24'h0, a[7:0]} + {24'h0, b[7:0]};
      4'h7: x.r = a & b;
      4'h8: x.r = a | b;
      4'h9: x.r = a ^ b;
      4'hA: x.r = ~a;
      4'hB: x.r = 32'd0 - a;
      default: x.r = '0;
    endcase
    return x;
  endfunction

  // External ALU: flags it does not define carry random junk.
  alu_res_t ev;
  always_comb begin
    ev = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
    bus.alu_out = ev.r;
    bus.alu_cf  = (bus.alu_op == 4'h0) ? ev.c : junk[0];
    bus.alu_of  = (bus.alu_op <= 4'h1) ? ev.o : junk[1];
    bus.alu_zf  = (ev.r == '0);
    bus.alu_sf  = (bus.alu_op <= 4'h1) ? ev.r[31] : junk[2];
  end

  always_comb begin
    bus4.alu_out = bus4.alu_a + bus4.alu_b;
    bus4.alu_cf  = 1'b0;
    bus4.alu_of  = 1'b0;
    bus4.alu_zf  = ((bus4.alu_a + bus4.alu_b) == '0);
    bus4.alu_sf  = 1'b0;
  end

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
    logic [31:0] aa;
    logic [31:0] ab;
    logic [3:0]  aop;
    int          edge_n;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  logic [31:0] m_chain = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [3:0]  m_op = '0;
  int force_hold = -1;

  task automatic issue(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ch,
    input bit          ovr,
    input logic [31:0] od,
    input logic [3:0]  ofl
  );
    exp_t e;
    alu_res_t x;
    logic [31:0] ae;
    int n;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_chain = ch;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout act=busy exp=ready");
      bus.cmd_valid = 1'b0;
      return;
    end
    e.edge_n = cyc + 1;
    if (op <= 4'hB) begin
      ae = (CHAIN && ch) ? m_chain : a;
      x = alu_f(op, ae, b);
      e.data  = ovr ? od : x.r;
      e.flags = ovr ? ofl :
        {(op == 4'h0) ? x.c : 1'b0,
         (op <= 4'h1) ? x.o : 1'b0,
         (x.r == '0),
         (op <= 4'h1) ? x.r[31] : 1'b0};
      e.err = 1'b0;
      e.lat = S1 + 1;
      m_a = ae;
      m_b = b;
      m_op = op;
      m_chain = e.data;
    end else begin
      e.data  = '0;
      e.flags = '0;
      e.err   = 1'b1;
      e.lat   = 0;
    end
    e.aa  = m_a;
    e.ab  = m_b;
    e.aop = m_op;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Response monitor: pops expectations, checks hold while stalled.
  initial begin
    exp_t e;
    bit seen;
    int hold;
    logic [31:0] sd, sa;
    logic [3:0] sf;
    logic se;
    seen = 0;
    hold = 0;
    sd = '0;
    sa = '0;
    sf = '0;
    se = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else if (bus.rsp_valid) begin
        chk("cmd_ready_in_resp", 32'(bus.cmd_ready), 32'd0);
        if (!seen) begin
          seen = 1;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp act=%h exp=none",
                     bus.rsp_data);
          end else begin
            e = sbq.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.flags));
            chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.edge_n), 32'(e.lat));
            chk("alu_a", bus.alu_a, e.aa);
            chk("alu_b", bus.alu_b, e.ab);
            chk("alu_op", 32'(bus.alu_op), 32'(e.aop));
          end
          sd = bus.rsp_data;
          sf = bus.rsp_flags;
          se = bus.rsp_err;
          sa = bus.alu_a;
          hold = (force_hold >= 0) ? force_hold
                                   : int'($urandom_range(0, 3));
          force_hold = -1;
        end else begin
          chk("hold_data", bus.rsp_data, sd);
          chk("hold_flags", 32'(bus.rsp_flags), 32'(sf));
          chk("hold_err", 32'(bus.rsp_err), 32'(se));
          chk("hold_alu_a", bus.alu_a, sa);
          if (hold > 0) hold--;
        end
        bus.rsp_ready = (hold == 0);
        if (hold == 0) seen = 0;
      end else begin
        seen = 0;
        bus.rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int acc;
    bit v_seen;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.cmd_chain  = 1'b0;
    bus4.cmd_valid = 1'b0;
    bus4.cmd_op    = '0;
    bus4.cmd_a     = '0;
    bus4.cmd_b     = '0;
    bus4.cmd_chain = 1'b0;
    bus4.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    issue(4'hD, 32'h1234, 32'h5678, 1'b0, 1'b0, '0, '0);
    issue(4'h0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1,
          32'h0, 4'b1010);
    force_hold = 5;
    issue(4'h1, 32'h8000_0000, 32'd1, 1'b0, 1'b1,
          32'h7FFF_FFFF, 4'b0100);
`ifdef ALU_SEQ_CHAIN_EN
    issue(4'h2, 32'd5, 32'd0, 1'b0, 1'b1, 32'd6, 4'b0000);
    issue(4'h2, 32'h100, 32'd0, 1'b1, 1'b1, 32'd7, 4'b0000);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(12, 15))
                                       : 4'($urandom_range(0, 11));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      issue(op, a, b, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((sbq.size() != 0 || bus.rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);

    // SETTLE_CYC=4 instance: latency, then reset mid-DRIVE.
    chk("s4_rst_data", bus4.rsp_data, 32'd0);
    rst4 = 1'b0;
    @(negedge clk);
    chk("s4_cmd_ready", 32'(bus4.cmd_ready), 32'd1);
    bus4.cmd_valid = 1'b1;
    bus4.cmd_op    = 4'h0;
    bus4.cmd_a     = 32'd10;
    bus4.cmd_b     = 32'd20;
    @(posedge clk);
    #1;
    bus4.cmd_valid = 1'b0;
    acc = cyc;
    @(negedge clk);
    while (!bus4.rsp_valid && (cyc - acc) < 20) @(negedge clk);
    chk("s4_latency", 32'(cyc - acc), 32'(S4 + 1));
    chk("s4_data", bus4.rsp_data, 32'd30);
    chk("s4_flags", 32'(bus4.rsp_flags), 32'd0);
    chk("s4_err", 32'(bus4.rsp_err), 32'd0);
    bus4.rsp_ready = 1'b1;
    @(negedge clk);
    bus4.rsp_ready = 1'b0;
    chk("s4_rsp_done", 32'(bus4.rsp_valid), 32'd0);

    bus4.cmd_valid = 1'b1;
    bus4.cmd_op    = 4'h1;
    bus4.cmd_a     = 32'd7;
    bus4.cmd_b     = 32'd8;
    @(posedge clk);
    #1;
    bus4.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("s4_drive_alu_a", bus4.alu_a, 32'd7);
    rst4 = 1'b1;
    #1;
    chk("s4_abort_valid", 32'(bus4.rsp_valid), 32'd0);
    chk("s4_abort_data", bus4.rsp_data, 32'd0);
    chk("s4_abort_flags", 32'(bus4.rsp_flags), 32'd0);
    chk("s4_abort_err", 32'(bus4.rsp_err), 32'd0);
    chk("s4_abort_alu_a", bus4.alu_a, 32'd0);
    chk("s4_abort_alu_b", bus4.alu_b, 32'd0);
    chk("s4_abort_alu_op", 32'(bus4.alu_op), 32'd0);
    @(negedge clk);
    rst4 = 1'b0;
    bus4.rsp_ready = 1'b1;
    @(negedge clk);
    chk("s4_post_ready", 32'(bus4.cmd_ready), 32'd1);
    v_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus4.rsp_valid) v_seen = 1'b1;
    end
    chk("s4_no_rsp", 32'(v_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 1, number of cycles ALU inputs are held before sampling; legal 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  sequencer accepts command this cycle.
REQ-006 cmd_op  input  4  ALU opcode.
REQ-007 cmd_a, cmd_b  input  32 each  operands.
REQ-008 cmd_chain  input  1  use previous result as A (see Configuration).
REQ-009 alu_a, alu_b  output  32 each  operands driven to the combinational ALU.
REQ-010 alu_op  output  4  opcode driven to the ALU.
REQ-011 alu_out  input  32  ALU result.
REQ-012 alu_cf, alu_of, alu_zf, alu_sf  input  1 each  ALU flags; may be high-Z for some opcodes.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_data  output  32  captured result.
REQ-016 rsp_flags  output  4  {C,O,Z,S}, masked.
REQ-017 rsp_err  output  1  illegal opcode.

Function
REQ-018 Opcodes 0x0-0xB SHALL be legal (ADD,SUB,INC,DEC,PASS,SHL,BADD,AND,OR,XOR,NOT,NEG); 0xC-0xF SHALL be illegal.
REQ-019 FSM states IDLE, DRIVE, CAPTURE, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-020 IDLE, cmd_valid&cmd_ready, legal op: register alu_a/alu_b/alu_op, load settle counter with SETTLE_CYC, go to DRIVE.
REQ-021 DRIVE SHALL decrement counter each cycle and go to CAPTURE when counter reaches 1.
REQ-022 CAPTURE SHALL register alu_out into rsp_data and masked flags into rsp_flags, then go to RESP.
REQ-023 Latency: accept at edge N, rsp_valid high after edge N+SETTLE_CYC+1.
REQ-024 Illegal op in IDLE SHALL skip the ALU: go directly to RESP with rsp_data=0, rsp_flags=0, rsp_err=1; alu_* unchanged.
REQ-025 RESP SHALL hold rsp_valid and all rsp_* stable until rsp_valid&rsp_ready, then return to IDLE; rsp_err cleared on next legal capture.
REQ-026 Flag mask: C = alu_cf for ADD only; O and S = alu_of/alu_sf for ADD and SUB only; Z = alu_zf for every legal op; masked-off bits SHALL be 0, never X/Z.
REQ-027 alu_a/alu_b/alu_op SHALL remain stable from DRIVE entry through CAPTURE and hold last values in IDLE/RESP.
REQ-028 No command SHALL be accepted while rsp_valid=1 (no overlap, one outstanding op).

Reset
REQ-029 On rst: state IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=0, counter=0, chain register=0.
REQ-030 Reset asserted in DRIVE/CAPTURE/RESP SHALL abort the operation; no response is produced.

Configuration
REQ-031 Macro ALU_SEQ_CHAIN_EN defined: every CAPTURE SHALL store rsp_data in a chain register; an accepted command with cmd_chain=1 SHALL drive alu_a from that register instead of cmd_a.
REQ-032 Macro ALU_SEQ_CHAIN_EN undefined: cmd_chain SHALL be ignored, no chain register exists, alu_a always from cmd_a.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the opcode enum (4-bit), FSM state enum, flag bit indices (C=3,O=2,Z=1,S=0), and the opcode-legality/flag-mask function.
REQ-034 No sub-module; the ALU is external and connects via the alu_* ports.

Verification
REQ-035 ADD A=0xFFFFFFFF, B=1, SETTLE_CYC=1 -> rsp_data=0, flags C=1,O=0,Z=1,S=0, rsp_valid 2 cycles after accept.
REQ-036 SUB A=0x80000000, B=1 -> rsp_data=0x7FFFFFFF, O=1, S=0, C=0, Z=0.
REQ-037 cmd_op=0xD -> rsp_valid after 1 cycle, rsp_err=1, rsp_data=0, alu_* unchanged.
REQ-038 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, second command accepted only after handshake.
REQ-039 rst pulsed mid-DRIVE with SETTLE_CYC=4 -> all outputs at reset values, no rsp_valid.
REQ-040 With ALU_SEQ_CHAIN_EN: INC A=5, then INC cmd_chain=1, cmd_a=0x100 -> results 6 then 7.
